rvfi_check_sequencer: RTL and testbench

- Cycle-level sequencer driving the reset/trig/check inputs of an rvfi checker instance (uniqueness, insn, causal and similar checks).
- Holds the checker in reset for a fixed number of cycles, then opens a trigger window and fires a single trig on the first cycle where the watched channel retires and the solver-chosen offset is reached.
- Fires check at a fixed depth; reports done/vacuous status to the formal wrapper.

---
 rtl/rvfi_check_sequencer.sv | 112 +++++++++++
 tb/tb_rvfi_check_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: cycle-level driver for the reset/trig/check inputs of
// an rvfi checker. Holds the checker in reset, opens a trigger window, fires
// one trig on a qualifying retire, then one check strobe at a fixed depth.
module rvfi_check_sequencer #(
   parameter int NRET         = 1,
   parameter int CHANNEL_IDX  = 0,
   parameter int RESET_CYCLES = 1,
   parameter int TRIG_MIN     = 10,
   parameter int TRIG_MAX     = 20,
   parameter int CHECK_CYCLE  = 25,
   parameter int CNT_W        = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NRET-1:0]  rvfi_valid,
   input  logic [CNT_W-1:0] trig_offset,
   output logic             chk_reset,
   output logic             chk_trig,
   output logic             chk_check,
   output logic [CNT_W-1:0] cycle,
   output logic             triggered,
   output logic             done,
   output logic             vacuous
);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(TRIG_MIN - 1);
   localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(TRIG_MIN);
   localparam logic [CNT_W-1:0] WIN_MAX  = CNT_W'(TRIG_MAX);
   localparam logic [CNT_W-1:0] WIN_LEN  = CNT_W'(TRIG_MAX - TRIG_MIN + 1);
   localparam logic [CNT_W-1:0] CHK_AT   = CNT_W'(CHECK_CYCLE);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {RST, ARM, WIN, HOLD, IDLE} state_t;

   state_t           state, state_nxt;
   logic             set_trig, set_vac, set_done;
   logic [CNT_W-1:0] trig_cycle;

   // Effective trigger cycle folded into the window from the solver's offset.
   assign trig_cycle = WIN_MIN + (trig_offset % WIN_LEN);

   // Reset input is OR'ed in so the checker sees reset in the same cycle.
   assign chk_reset = (state == RST) || reset;

   // Next-state and strobe decode; strobes are suppressed while reset is high
   // so an aborted epoch can never emit trig or check.
   always_comb begin
      state_nxt = state;
      chk_trig  = 1'b0;
      chk_check = 1'b0;
      set_trig  = 1'b0;
      set_vac   = 1'b0;
      set_done  = 1'b0;
      case (state)
         RST:  if (cycle == RST_LAST) state_nxt = ARM;
         ARM:  if (cycle == ARM_LAST) state_nxt = WIN;
         WIN: begin
            if (rvfi_valid[CHANNEL_IDX] && cycle >= trig_cycle && cycle <= WIN_MAX) begin
               chk_trig  = 1'b1;
               set_trig  = 1'b1;
               state_nxt = HOLD;
            end else if (cycle == WIN_MAX) begin
               set_vac   = 1'b1;
               set_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (cycle == CHK_AT) begin
               chk_check = 1'b1;
               set_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (reset) begin
         chk_trig  = 1'b0;
         chk_check = 1'b0;
      end
   end

   // State, saturating cycle counter and sticky status flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= RST;
         cycle     <= '0;
         triggered <= 1'b0;
         done      <= 1'b0;
         vacuous   <= 1'b0;
      end else begin
         state     <= state_nxt;
         if (cycle != CNT_MAX) cycle <= cycle + 1'b1;
         triggered <= triggered | set_trig;
         done      <= done | set_done;
         vacuous   <= vacuous | set_vac;
      end
   end

`ifdef RISCV_FORMAL
   // Internal consistency properties for the formal flow.
   always_comb begin
      if (!reset) begin
         assert (!triggered || cycle <= CHK_AT || done);
         assert (!chk_check || triggered);
         assert (!vacuous || !triggered);
      end
   end
`endif

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Bench for rvfi_check_sequencer: directed table, reset abort, counter
// saturation and randomized epochs against an epoch-level reference model.
module tb_rvfi_check_sequencer;
   localparam int NRET = 1, CH = 0, RC = 3, TMIN = 10, TMAX = 20, CHK = 25, W = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [NRET-1:0] rvfi_valid = '0;
   logic [W-1:0]    trig_offset = '0;
   logic            chk_reset, chk_trig, chk_check, triggered, done, vacuous;
   logic [W-1:0]    cycle;

   rvfi_check_sequencer #(
      .NRET(NRET), .CHANNEL_IDX(CH), .RESET_CYCLES(RC), .TRIG_MIN(TMIN),
      .TRIG_MAX(TMAX), .CHECK_CYCLE(CHK), .CNT_W(W)
   ) dut (
      .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid),
      .trig_offset(trig_offset), .chk_reset(chk_reset), .chk_trig(chk_trig),
      .chk_check(chk_check), .cycle(cycle), .triggered(triggered),
      .done(done), .vacuous(vacuous)
   );

   always #5 clock = ~clock;

   int checks = 0, errors = 0;

   typedef struct {
      logic [W-1:0] off;
      logic [63:0]  mask;      // rvfi_valid per cycle index
      int           exp_trig;  // cycle of trig, -1 = vacuous
      int           abort_at;  // cycle reset is re-asserted, -1 = none
      int           ncyc;
   } vec_t;

   vec_t tbl[10];

   task automatic cmp(input string name, input int c, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d", name, c, act, exp);
      end
   endtask

   // Reference: first retire at or after the folded offset, within the window.
   function automatic int model_trig(input logic [W-1:0] off, input logic [63:0] mask);
      int t;
      t = TMIN + int'(off) % (TMAX - TMIN + 1);
      for (int c = t; c <= TMAX; c++)
         if (mask[c]) return c;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      rvfi_valid = '0;
      @(posedge clock); #1;
      @(negedge clock);
      cmp("rst_chk_reset", -1, chk_reset, 1);
      cmp("rst_cycle", -1, cycle, 0);
      cmp("rst_trig", -1, chk_trig, 0);
      cmp("rst_check", -1, chk_check, 0);
      cmp("rst_triggered", -1, triggered, 0);
      cmp("rst_done", -1, done, 0);
      cmp("rst_vacuous", -1, vacuous, 0);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic run_epoch(input vec_t v);
      int  tr;
      bit  hit;
      trig_offset = v.off;
      do_reset();
      tr  = v.exp_trig;
      hit = (tr >= 0);
      for (int c = 0; c < v.ncyc; c++) begin
         rvfi_valid[CH] = (c < 64) ? v.mask[c] : 1'($urandom);
         if (c == v.abort_at) reset = 1'b1;
         @(negedge clock);
         if (v.abort_at >= 0 && c > v.abort_at) begin
            cmp("ab_chk_reset", c, chk_reset, 1);
            cmp("ab_trig", c, chk_trig, 0);
            cmp("ab_check", c, chk_check, 0);
            cmp("ab_cycle", c, cycle, 0);
            cmp("ab_triggered", c, triggered, 0);
            cmp("ab_done", c, done, 0);
            cmp("ab_vacuous", c, vacuous, 0);
         end else if (c == v.abort_at) begin
            cmp("ab_chk_reset", c, chk_reset, 1);
            cmp("ab_trig", c, chk_trig, 0);
            cmp("ab_check", c, chk_check, 0);
         end else begin
            cmp("chk_reset", c, chk_reset, int'(c < RC));
            cmp("chk_trig", c, chk_trig, int'(hit && c == tr));
            cmp("chk_check", c, chk_check, int'(hit && c == CHK));
            cmp("cycle", c, cycle, (c > 255) ? 255 : c);
            cmp("triggered", c, triggered, int'(hit && c > tr));
            cmp("done", c, done, int'(hit ? (c > CHK) : (c > TMAX)));
            cmp("vacuous", c, vacuous, int'(!hit && c > TMAX));
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{8'd4,   64'hFFFF_FFFF_FFFF_FFFF,           14, -1, 30};
      tbl[1] = '{8'd4,   (64'd1 << 12) | (64'd1 << 17),     17, -1, 30};
      tbl[2] = '{8'd10,  64'd0,                             -1, -1, 30};
      tbl[3] = '{8'd10,  64'd1 << 20,                       20, -1, 30};
      tbl[4] = '{8'd0,   (64'd1 << 9) | (64'd1 << 10),      10, -1, 30};
      tbl[5] = '{8'd11,  64'd1 << 10,                       10, -1, 30};
      tbl[6] = '{8'd255, (64'd1 << 11) | (64'd1 << 13) | (64'd1 << 21), 13, -1, 30};
      tbl[7] = '{8'd3,   64'hFFE0_1FFF,                     -1, -1, 30};
      // trigger at 14 then reset at 22: check at 25 must be dropped
      tbl[8] = '{8'd4,   64'hFFFF_FFFF_FFFF_FFFF,           14, 22, 30};
      // long run: counter saturates, terminal state holds
      tbl[9] = '{8'd4,   64'hFFFF_FFFF_FFFF_FFFF,           14, -1, 262};

      for (int i = 0; i < 10; i++) run_epoch(tbl[i]);

      for (int i = 0; i < 24; i++) begin
         v.off  = W'($urandom);
         v.mask = {$urandom & $urandom, $urandom & $urandom};
         if (i % 4 == 0) v.mask = v.mask & ~(64'h1F_FC00);
         v.exp_trig = model_trig(v.off, v.mask);
         v.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 29)) : -1;
         v.ncyc = 30;
         run_epoch(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
